// File: rtl/operand_wakeup_queue.sv
// Age-ordered operand wakeup queue: holds renamed instructions until both
// source operands arrive from the register file, ROB or CDB, then issues.
module operand_wakeup_queue #(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_busy,
    input  logic [WIDTH:0]               in_operand1,
    input  logic [WIDTH:0]               in_operand2,
    input  logic [WIDTH+1:0]             in_robvalue1,
    input  logic [WIDTH+1:0]             in_robvalue2,
    input  logic [ROB:0]                 in_tag1,
    input  logic [ROB:0]                 in_tag2,
    input  logic [ROB:0]                 in_dest,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*(ROB+1)-1:0]   cdb_rob,
    input  logic [NUM_CDB*(WIDTH+1)-1:0] cdb_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [WIDTH:0]        out_op1,
    output logic signed [WIDTH:0]        out_op2,
    output logic [ROB:0]                 out_dest,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic           rdy;
        logic [ROB:0]   tag;
        logic [WIDTH:0] val;
    } src_t;

    typedef struct packed {
        logic         vld;
        logic [ROB:0] dest;
        src_t         s1;
        src_t         s2;
    } ent_t;

    ent_t q   [DEPTH];
    ent_t snp [DEPTH];
    ent_t nq  [DEPTH];
    ent_t newe;

    logic [DEPTH-1:0] can_issue;
    logic [DEPTH-1:0] shift;
    logic [CW-1:0]    wr_idx;
    logic [CW-1:0]    ncount;
    logic             issue;
    logic             alloc;
    logic             run;

    // Scan high to low so the lowest-indexed matching port wins.
    function automatic src_t snoop(
        input src_t                         s,
        input logic [NUM_CDB-1:0]           cv,
        input logic [NUM_CDB*(ROB+1)-1:0]   cr,
        input logic [NUM_CDB*(WIDTH+1)-1:0] cd
    );
        src_t r;
        r = s;
        if (!s.rdy) begin
            for (int k = NUM_CDB-1; k >= 0; k--) begin
                if (cv[k] && cr[k*(ROB+1) +: ROB+1] == s.tag) begin
                    r.rdy = 1'b1;
                    r.val = cd[k*(WIDTH+1) +: WIDTH+1];
                end
            end
        end
        return r;
    endfunction

    function automatic src_t resolve(
        input logic                         busy,
        input logic [WIDTH:0]               opnd,
        input logic [WIDTH+1:0]             robv,
        input logic [ROB:0]                 tag,
        input logic [NUM_CDB-1:0]           cv,
        input logic [NUM_CDB*(ROB+1)-1:0]   cr,
        input logic [NUM_CDB*(WIDTH+1)-1:0] cd
    );
        src_t r;
        r.tag = tag;
        r.rdy = 1'b1;
        r.val = opnd;
        if (busy) begin
            if (robv[WIDTH+1]) begin
                r.val = robv[WIDTH:0];
            end else begin
                r.rdy = 1'b0;
                r.val = '0;
                r     = snoop(r, cv, cr, cd);
            end
        end
        return r;
    endfunction

    assign in_ready = (count < DEPTH_C);

    always_comb begin
        out_op1  = '0;
        out_op2  = '0;
        out_dest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            can_issue[i] = q[i].vld & q[i].s1.rdy & q[i].s2.rdy;
        end
        out_valid = |can_issue;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (can_issue[i]) begin
                out_op1  = $signed(q[i].s1.val);
                out_op2  = $signed(q[i].s2.val);
                out_dest = q[i].dest;
            end
        end
    end

    always_comb begin
        issue = out_valid & out_ready;
        alloc = in_valid & in_ready & ~flush;
        run   = 1'b0;
        // Every entry at or above the issued one moves down one slot.
        for (int i = 0; i < DEPTH; i++) begin
            run      = run | can_issue[i];
            shift[i] = issue & run;
            snp[i]   = q[i];
            if (q[i].vld) begin
                snp[i].s1 = snoop(q[i].s1, cdb_valid, cdb_rob, cdb_result);
                snp[i].s2 = snoop(q[i].s2, cdb_valid, cdb_rob, cdb_result);
            end
        end
        for (int i = 0; i < DEPTH-1; i++) begin
            nq[i] = shift[i] ? snp[i+1] : snp[i];
        end
        nq[DEPTH-1] = shift[DEPTH-1] ? '0 : snp[DEPTH-1];

        newe.vld  = 1'b1;
        newe.dest = in_dest;
        newe.s1   = resolve(in_busy[0], in_operand1, in_robvalue1, in_tag1,
                            cdb_valid, cdb_rob, cdb_result);
        newe.s2   = resolve(in_busy[1], in_operand2, in_robvalue2, in_tag2,
                            cdb_valid, cdb_rob, cdb_result);

        wr_idx = count - {{(CW-1){1'b0}}, issue};
        if (alloc) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CW'(i)) nq[i] = newe;
            end
        end
        ncount = wr_idx + {{(CW-1){1'b0}}, alloc};

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) nq[i] = '0;
            ncount = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
            count <= ncount;
        end
    end

endmodule

// File: tb/tb_operand_wakeup_queue.sv
// Scoreboard bench for operand_wakeup_queue: directed scenarios then random
// traffic against a list-based reference model.
module tb_operand_wakeup_queue;

    localparam int W  = 31;
    localparam int R  = 2;
    localparam int D  = 4;
    localparam int NC = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              flush, in_valid, out_ready;
    logic [1:0]        in_busy;
    logic [W:0]        in_operand1, in_operand2;
    logic [W+1:0]      in_robvalue1, in_robvalue2;
    logic [R:0]        in_tag1, in_tag2, in_dest;
    logic [NC-1:0]     cdb_valid;
    logic [R:0]        crob [NC];
    logic [W:0]        cres [NC];
    logic [NC*(R+1)-1:0] cdb_rob;
    logic [NC*(W+1)-1:0] cdb_result;
    logic              in_ready, out_valid;
    logic signed [W:0] out_op1, out_op2;
    logic [R:0]        out_dest;
    logic [2:0]        count;

    assign cdb_rob    = {crob[1], crob[0]};
    assign cdb_result = {cres[1], cres[0]};

    operand_wakeup_queue #(.WIDTH(W), .ROB(R), .DEPTH(D), .NUM_CDB(NC)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_busy(in_busy),
        .in_operand1(in_operand1), .in_operand2(in_operand2),
        .in_robvalue1(in_robvalue1), .in_robvalue2(in_robvalue2),
        .in_tag1(in_tag1), .in_tag2(in_tag2), .in_dest(in_dest),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_result(cdb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_dest(out_dest),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [2:0]  dest;
        bit        r1;
        bit [2:0]  t1;
        bit [31:0] v1;
        bit        r2;
        bit [2:0]  t2;
        bit [31:0] v2;
    } ment_t;

    typedef struct {
        bit [31:0] a;
        bit [31:0] b;
        bit [2:0]  d;
    } exp_t;

    ment_t mq [$];
    exp_t  sb [$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit cdb_find(input bit [2:0] t, output bit [31:0] v);
        v = 0;
        for (int k = 0; k < NC; k++) begin
            if (cdb_valid[k] && crob[k] == t) begin
                v = cres[k];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void resolve(input bit busy, input bit [31:0] op,
                                    input bit [32:0] rv, input bit [2:0] t,
                                    output bit r, output bit [31:0] v);
        r = 1'b1;
        v = op;
        if (busy) begin
            if (rv[32]) v = rv[31:0];
            else r = cdb_find(t, v);
        end
    endfunction

    function automatic int first_ready();
        foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    task automatic idle();
        flush = 0; in_valid = 0; out_ready = 0; in_busy = 0;
        in_operand1 = 0; in_operand2 = 0; in_robvalue1 = 0; in_robvalue2 = 0;
        in_tag1 = 0; in_tag2 = 0; in_dest = 0; cdb_valid = 0;
        for (int k = 0; k < NC; k++) begin
            crob[k] = 0;
            cres[k] = 0;
        end
    endtask

    // One clock: compare state outputs, predict, advance model past the edge.
    task automatic cycle();
        int    fi;
        bit    alloc;
        bit    r1, r2;
        bit [31:0] v1, v2;
        ment_t ne;
        fi = first_ready();
        chk("count", count, mq.size());
        chk("in_ready", in_ready, (mq.size() < D));
        chk("out_valid", out_valid, (fi >= 0));
        if (fi < 0) begin
            chk("idle_op1", out_op1, 0);
            chk("idle_dest", out_dest, 0);
        end
        if (fi >= 0 && out_ready) sb.push_back('{mq[fi].v1, mq[fi].v2, mq[fi].dest});
        alloc = in_valid && (mq.size() < D) && !flush;
        resolve(in_busy[0], in_operand1, in_robvalue1, in_tag1, r1, v1);
        resolve(in_busy[1], in_operand2, in_robvalue2, in_tag2, r2, v2);
        @(posedge clk);
        foreach (mq[i]) begin
            bit [31:0] v;
            if (!mq[i].r1 && cdb_find(mq[i].t1, v)) begin
                mq[i].r1 = 1'b1;
                mq[i].v1 = v;
            end
            if (!mq[i].r2 && cdb_find(mq[i].t2, v)) begin
                mq[i].r2 = 1'b1;
                mq[i].v2 = v;
            end
        end
        if (fi >= 0 && out_ready) mq.delete(fi);
        if (alloc) begin
            ne = '{in_dest, r1, in_tag1, v1, r2, in_tag2, v2};
            mq.push_back(ne);
        end
        if (flush) mq.delete();
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue dest %0h want none", out_dest);
            end else begin
                e = sb.pop_front();
                chk("iss_op1", out_op1, e.a);
                chk("iss_op2", out_op2, e.b);
                chk("iss_dest", out_dest, e.d);
            end
        end
    end

    initial begin
        idle();
        #12;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_op1", out_op1, 0);
        chk("rst_dest", out_dest, 0);
        @(negedge clk);
        reset_n = 1;

        in_valid = 1; in_operand1 = 5; in_operand2 = -3; in_dest = 4;
        cycle();
        idle();
        chk("r032_valid", out_valid, 1);
        chk("r032_op1", out_op1, 5);
        chk("r032_op2", out_op2, 32'hFFFF_FFFD);
        chk("r032_dest", out_dest, 4);
        out_ready = 1;
        cycle();
        idle();
        cycle();

        in_valid = 1; in_busy = 2'b11; in_tag1 = 2; in_tag2 = 3; in_dest = 1;
        cycle();
        idle();
        out_ready = 1;
        cdb_valid = 2'b10; crob[1] = 2; cres[1] = 10;
        cycle();
        cdb_valid = 2'b01; crob[0] = 3; cres[0] = 20;
        cycle();
        cdb_valid = 0;
        chk("r033_valid", out_valid, 1);
        chk("r033_op1", out_op1, 10);
        chk("r033_op2", out_op2, 20);
        cycle();
        idle();

        in_valid = 1; in_busy = 2'b01; in_tag1 = 6; in_operand2 = 9; in_dest = 2;
        cdb_valid = 2'b01; crob[0] = 6; cres[0] = 7;
        cycle();
        idle();
        chk("r034_op1", out_op1, 7);
        out_ready = 1;
        cycle();
        idle();

        in_valid = 1; in_busy = 2'b10; in_tag2 = 1; in_dest = 5;
        cdb_valid = 2'b11; crob[0] = 1; cres[0] = 11; crob[1] = 1; cres[1] = 22;
        cycle();
        idle();
        chk("cdb_prio_op2", out_op2, 11);
        out_ready = 1;
        cycle();
        idle();

        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_busy = 2'b01; in_tag1 = 5; in_dest = 3'(i);
            cycle();
        end
        in_busy = 0; in_operand1 = 77; in_dest = 3;
        cycle();
        idle();
        chk("r035_count", count, 4);
        chk("r035_inrdy", in_ready, 0);
        chk("r035_dest", out_dest, 3);
        out_ready = 1; in_valid = 1; in_operand1 = 88; in_dest = 7;
        cycle();
        idle();
        chk("r035_after", count, 3);
        cdb_valid = 2'b01; crob[0] = 5; cres[0] = 55;
        cycle();
        idle();
        in_valid = 1; out_ready = 1; in_operand1 = 99; in_dest = 6;
        cycle();
        idle();
        chk("r035_swap", count, 3);

        in_valid = 1; flush = 1;
        cycle();
        idle();
        chk("r036_count", count, 0);
        chk("r036_valid", out_valid, 0);

        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_busy = 2'b01; in_tag1 = 4; in_dest = 3'(i);
            cycle();
        end
        idle();
        chk("r037_pre", count, 2);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("r037_count", count, 0);
        chk("r037_valid", out_valid, 0);
        chk("r037_inrdy", in_ready, 1);
        mq.delete();
        @(negedge clk);
        reset_n = 1;
        in_valid = 1; in_operand1 = 3; in_operand2 = 4; in_dest = 1;
        cycle();
        idle();
        chk("r031_count", count, 1);

        repeat (3000) begin
            flush        = ($urandom_range(0, 99) < 3);
            in_valid     = ($urandom_range(0, 9) < 6);
            out_ready    = ($urandom_range(0, 9) < 7);
            in_busy      = 2'($urandom());
            in_operand1  = $urandom();
            in_operand2  = $urandom();
            in_robvalue1 = {1'($urandom_range(0, 3) == 0), 32'($urandom())};
            in_robvalue2 = {1'($urandom_range(0, 3) == 0), 32'($urandom())};
            in_tag1      = 3'($urandom());
            in_tag2      = 3'($urandom());
            in_dest      = 3'($urandom());
            cdb_valid    = 2'($urandom());
            for (int k = 0; k < NC; k++) begin
                crob[k] = 3'($urandom());
                cres[k] = $urandom();
            end
            cycle();
        end
        idle();
        cycle();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
